uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serial UART-style transmitter. It converts a WIDTH-bit parallel word into an asynchronous serial frame: start bit (0), WIDTH data bits LSB first, then one stop bit (1). It sends one bit per clock cycle, so the bit rate equals the clock rate; any baud-rate division is handled upstream by the clock or enable source. It sits between a parallel data producer, which pulses d_ready, and the serial line tx_data.

Parameters:
WIDTH, 8, number of data bits per frame (supported values 1 to 16); frame length is WIDTH+2 cycles.

Ports:
clk  input  1  system clock; all logic is updated on the rising edge.
rstn  input  1  reset; synchronous, active-high (asserted = 1). The name follows the codebase convention, and the polarity is high.
en  input  1  transmitter enable; when low, the block is held idle.
d_ready  input  1  one-cycle strobe: d_in is valid and a frame is requested.
d_in  input  WIDTH  parallel data word to send.
tx_data  output  1  serial line output; registered; idles high.

Behaviour:
- Reset (rstn=1 at a rising clk edge): state=IDLE, tx_data=1, bit counter=0, shift register=0. Reset has priority over every other input and aborts any frame in flight. Output is high from the next edge.
- States are IDLE, START, DATA, STOP. tx_data is driven from a register that is updated on the same edge as the state.
- IDLE: tx_data=1. If en=1 and d_ready=1 at an edge, latch d_in into the shift register, go to START, and drive tx_data=0 from that edge. If d_ready=0 or en=0, stay in IDLE.
- START: lasts 1 cycle. On the next edge, go to DATA, drive tx_data=shift[0], and set counter=0.
- DATA: lasts WIDTH cycles, one bit per cycle, LSB first. On each edge, shift right and increment the counter. After bit WIDTH-1 has been on the line for one cycle, go to STOP with tx_data=1.
- STOP: lasts 1 cycle with tx_data=1. On the next edge:
  - If en=1 and d_ready=1, latch d_in and go directly to START (tx_data=0). Back-to-back frames therefore repeat every WIDTH+2 cycles.
  - Otherwise, go to IDLE.
- Latency: the start bit appears on tx_data on the same rising edge that samples d_ready=1. Data bit i is on the line during cycle i+1 after that edge, and the stop bit during cycle WIDTH+1.
- d_ready asserted while in START or DATA is ignored. It is not queued and the frame in flight is not disturbed. d_in is sampled only at the accept edge, so later changes to d_in do not affect the frame in flight.
- en deasserted at any edge while not in IDLE aborts the frame: go to IDLE and set tx_data=1 from that edge. If en=0 and d_ready=1 arrive together, no frame is accepted.
- If d_ready stays high continuously with en=1, frames are sent back to back, and each frame latches the current d_in at its accept edge.
- The counter width is clog2(WIDTH) bits (minimum 1) and never wraps past WIDTH-1.

Test Plan:
- Reset: hold rstn=1 for 1 cycle with en=0, then release -> tx_data=1 and the block stays in IDLE with no activity while d_ready=0.
- Single frame: en=1, d_in=0x24, one-cycle d_ready pulse -> tx_data over 10 cycles = 0,0,0,1,0,0,1,0,0,1 (start, LSB first, stop), then stays 1.
- Spaced frames: after the frame above, wait 11 cycles, then send d_in=0x25, then send d_in=0x81 -> start,1,0,1,0,0,1,0,0,stop followed by start,1,0,0,0,0,0,0,1,stop, with tx_data=1 between frames.
- Back-to-back: hold d_ready=1 during the STOP cycle with d_in=0xFF -> the next start bit follows the stop bit with no idle gap; bits are 0 then eight 1s then 1.
- Ignore while busy: pulse d_ready with d_in=0x00 during DATA bit 3 of a 0xA5 frame -> the frame remains 0,1,0,1,0,0,1,0,1,1 and no extra frame follows.
- Abort: drop en (or assert rstn) mid-DATA -> tx_data=1 from that edge, state is IDLE, and a new d_ready with en=1 starts a clean frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// ============================================================================
// uart_transmitter
// ----------------------------------------------------------------------------
// Purpose:
//   Converts a WIDTH-bit parallel word into an asynchronous serial frame:
//   one start bit (0), WIDTH data bits sent LSB first, then one stop bit (1).
//   One bit is sent per clock cycle. Any baud-rate division is done upstream
//   by the clock or enable source.
//
// Ports:
//   clk      in   1      system clock, rising-edge active
//   rstn     in   1      synchronous reset, active-high (1 = reset)
//   en       in   1      transmitter enable; low holds/returns the block idle
//   d_ready  in   1      one-cycle strobe: d_in valid, a frame is requested
//   d_in     in   WIDTH  parallel data word to send
//   tx_data  out  1      registered serial line, idles high
//
// Parameters:
//   WIDTH    data bits per frame (1..16); one frame takes WIDTH+2 cycles
// ============================================================================
module uart_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             d_ready,
    input  logic [WIDTH-1:0] d_in,
    output logic             tx_data
);

    // The bit counter needs to reach WIDTH-1; keep at least one bit so that
    // WIDTH=1 still produces a legal vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    bit_cnt;

    // Single registered FSM. The line output is updated on the same edge as
    // the state, so tx_data always reflects the bit of the current state.
    // The shift register is consumed from bit 0: each time a data bit is put
    // on the line the register moves right, so shift[0] is always the next
    // bit to send.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            tx_data <= 1'b1;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (!en) begin
            // Dropping enable aborts any frame in flight and refuses a
            // simultaneous request.
            state   <= IDLE;
            tx_data <= 1'b1;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_data <= 1'b1;
                    if (d_ready) begin
                        shift   <= d_in;
                        state   <= START;
                        tx_data <= 1'b0;
                    end
                end

                START: begin
                    state   <= DATA;
                    tx_data <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= '0;
                end

                DATA: begin
                    // bit_cnt is the index of the bit currently on the line;
                    // once the last one has had its cycle, emit the stop bit.
                    if (bit_cnt == LAST_BIT) begin
                        state   <= STOP;
                        tx_data <= 1'b1;
                    end else begin
                        tx_data <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // A request arriving during the stop bit chains straight
                    // into the next start bit with no idle gap.
                    if (d_ready) begin
                        shift   <= d_in;
                        state   <= START;
                        tx_data <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        tx_data <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx_data <= 1'b1;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// tb_uart_transmitter
// ----------------------------------------------------------------------------
// Directed bench for uart_transmitter (WIDTH=8). Inputs change on the falling
// edge, tx_data is sampled on the falling edge, so every sample sits half a
// cycle away from the active rising edge. Sample k is the line value during
// cycle k after the edge that accepts a frame (k=0 is the start bit).
// ============================================================================
module tb_uart_transmitter;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       d_ready;
    logic [7:0] d_in;
    logic       tx_data;

    int total;
    int bad;

    uart_transmitter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .d_ready (d_ready),
        .d_in    (d_in),
        .tx_data (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests one frame with a one-cycle d_ready pulse and records n line
    // samples starting with the start-bit cycle. Called right after a falling
    // edge; returns right after the last sampling falling edge.
    task automatic send_and_collect(input logic [7:0] value, input int n,
                                    output logic [31:0] samples);
        samples = '0;
        d_in    = value;
        d_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            samples[k] = tx_data;
            d_ready    = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn    = 1'b1;
        en      = 1'b0;
        d_ready = 1'b0;
        d_in    = 8'h00;
        @(negedge clk);
        total++;
        if (tx_data !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_value got=%b want=1", tx_data);
        end
        rstn = 1'b0;
        en   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (tx_data !== 1'b1) begin
                bad++;
                $display("[TB] FAIL idle_no_request k=%0d got=%b want=1", k, tx_data);
            end
        end
        // Request with enable low must not be accepted.
        en      = 1'b0;
        d_in    = 8'h00;
        d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d_ready = 1'b0;
            total++;
            if (tx_data !== 1'b1) begin
                bad++;
                $display("[TB] FAIL request_while_disabled k=%0d got=%b want=1", k, tx_data);
            end
        end
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [31:0] s;
        // 0x24: start 0, bits 0,0,1,0,0,1,0,0, stop 1, idle 1 (bit k = sample k)
        logic [10:0] want = 11'b110_0100_1000;
        send_and_collect(8'h24, 11, s);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (s[k] !== want[k]) begin
                bad++;
                $display("[TB] FAIL single_frame_0x24 k=%0d got=%b want=%b", k, s[k], want[k]);
            end
        end
    endtask

    task automatic test_spaced_frames();
        logic [31:0] s;
        // 0x25: 0, 1,0,1,0,0,1,0,0, 1, idle 1
        logic [10:0] want_a = 11'b110_0100_1010;
        // 0x81: 0, 1,0,0,0,0,0,0,1, 1, idle 1
        logic [10:0] want_b = 11'b111_0000_0010;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            total++;
            if (tx_data !== 1'b1) begin
                bad++;
                $display("[TB] FAIL gap_idle k=%0d got=%b want=1", k, tx_data);
            end
        end
        send_and_collect(8'h25, 11, s);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (s[k] !== want_a[k]) begin
                bad++;
                $display("[TB] FAIL spaced_frame_0x25 k=%0d got=%b want=%b", k, s[k], want_a[k]);
            end
        end
        send_and_collect(8'h81, 11, s);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (s[k] !== want_b[k]) begin
                bad++;
                $display("[TB] FAIL spaced_frame_0x81 k=%0d got=%b want=%b", k, s[k], want_b[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic s[22];
        // 0x24 frame, then 0xFF chained from its stop bit, then idle.
        logic want[22] = '{0,0,0,1,0,0,1,0,0,1,
                           0,1,1,1,1,1,1,1,1,1,
                           1,1};
        d_in    = 8'h24;
        d_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            s[k] = tx_data;
            if (k == 0) d_ready = 1'b0;
            if (k == 9) begin
                d_in    = 8'hFF;
                d_ready = 1'b1;
            end
            if (k == 10) d_ready = 1'b0;
        end
        for (int k = 0; k < 22; k++) begin
            total++;
            if (s[k] !== want[k]) begin
                bad++;
                $display("[TB] FAIL back_to_back k=%0d got=%b want=%b", k, s[k], want[k]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic s[16];
        // 0xA5 frame must stay intact and nothing may follow it.
        logic want[16] = '{0,1,0,1,0,0,1,0,1,1,
                           1,1,1,1,1,1};
        d_in    = 8'hA5;
        d_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s[k] = tx_data;
            if (k == 0) d_ready = 1'b0;
            if (k == 4) begin
                d_in    = 8'h00;
                d_ready = 1'b1;
            end
            if (k == 5) d_ready = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (s[k] !== want[k]) begin
                bad++;
                $display("[TB] FAIL ignore_busy k=%0d got=%b want=%b", k, s[k], want[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] s;
        logic [10:0] want_a = 11'b110_0100_1010;
        logic [10:0] want_b = 11'b111_0000_0010;
        // Enable drop during an all-zero frame: line goes high at once.
        d_in    = 8'h00;
        d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d_ready = 1'b0;
            total++;
            if (tx_data !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_en_pre k=%0d got=%b want=0", k, tx_data);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (tx_data !== 1'b1) begin
                bad++;
                $display("[TB] FAIL abort_en_line k=%0d got=%b want=1", k, tx_data);
            end
        end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (tx_data !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_en_idle got=%b want=1", tx_data);
        end
        send_and_collect(8'h25, 11, s);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (s[k] !== want_a[k]) begin
                bad++;
                $display("[TB] FAIL after_en_abort k=%0d got=%b want=%b", k, s[k], want_a[k]);
            end
        end
        // Reset during an all-zero frame.
        d_in    = 8'h00;
        d_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            d_ready = 1'b0;
        end
        total++;
        if (tx_data !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_rst_pre got=%b want=0", tx_data);
        end
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        total++;
        if (tx_data !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_rst_line got=%b want=1", tx_data);
        end
        @(negedge clk);
        total++;
        if (tx_data !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_rst_idle got=%b want=1", tx_data);
        end
        send_and_collect(8'h81, 11, s);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (s[k] !== want_b[k]) begin
                bad++;
                $display("[TB] FAIL after_rst_abort k=%0d got=%b want=%b", k, s[k], want_b[k]);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rstn    = 1'b1;
        en      = 1'b0;
        d_ready = 1'b0;
        d_in    = 8'h00;
        test_reset();
        test_single_frame();
        test_spaced_frames();
        @(negedge clk);
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
